// File: rtl/vram_bus_initiator_pkg.sv
// Shared definitions for the video-RAM bus initiator: FSM encoding, bus
// direction codes and the default dtack timeout.
package vram_bus_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STRB = 2'd1,
        ST_WAIT = 2'd2,
        ST_RECV = 2'd3
    } vbi_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int unsigned VBI_TMO_DEFAULT = 255;
    localparam int unsigned VBI_TMO_W       = 8;

endpackage

// File: rtl/vram_bus_initiator_timeout.sv
// Loadable down-counter bounding how long a bus cycle may wait for dtack.
// Loaded with TMO-1 so the zero flag is seen on the TMO-th wait cycle.
module vram_bus_initiator_timeout #(
    parameter int unsigned W   = 8,
    parameter int unsigned TMO = 255
) (
    input  logic cl,
    input  logic reset_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge cl or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= W'(TMO - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vram_bus_initiator.sv
// Command-driven bus master for the video-RAM CPU-side bus: runs single or
// incrementing multi-word read/write transfers with a dtack timeout.
module vram_bus_initiator
    import vram_bus_initiator_pkg::*;
#(
    parameter int unsigned AW  = 23,
    parameter int unsigned DW  = 16,
    parameter int unsigned LW  = 8,
    parameter int unsigned TMO = VBI_TMO_DEFAULT
) (
    input  logic          cl,
    input  logic          reset_n,
    input  logic          cmd_req,
    output logic          cmd_ack,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [1:0]    cmd_be,
    input  logic [DW-1:0] cmd_wdata,
    output logic          busy,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] ad,
    output logic          as,
    output logic          rw,
    output logic          uds,
    output logic          lds,
    output logic [DW-1:0] od,
    input  logic          dtack,
    input  logic          dv,
    input  logic [DW-1:0] id
);

    vbi_state_e    state_q;
    logic          cmd_ack_q, busy_q, rd_valid_q, done_q, err_q;
    logic          as_q, rw_q, uds_q, lds_q;
    logic [AW-1:0] ad_q;
    logic [DW-1:0] od_q, rd_data_q;

    // Latched command
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] left_q;
    logic [1:0]    be_q;
    logic [DW-1:0] wdata_q;

    logic tmo_load, tmo_dec, tmo_zero;

    assign tmo_load = (state_q == ST_STRB);
    assign tmo_dec  = (state_q == ST_WAIT) && !dtack;

    vram_bus_initiator_timeout #(
        .W   (VBI_TMO_W),
        .TMO (TMO)
    ) u_timeout (
        .cl      (cl),
        .reset_n (reset_n),
        .load_i  (tmo_load),
        .dec_i   (tmo_dec),
        .zero_o  (tmo_zero)
    );

    always_ff @(posedge cl or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cmd_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            as_q       <= 1'b0;
            rw_q       <= RW_READ;
            uds_q      <= 1'b0;
            lds_q      <= 1'b0;
            ad_q       <= '0;
            od_q       <= '0;
            rd_data_q  <= '0;
            wr_q       <= RW_READ;
            addr_q     <= '0;
            left_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            cmd_ack_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_req) begin
                        cmd_ack_q <= 1'b1;
                        busy_q    <= 1'b1;
                        wr_q      <= cmd_wr;
                        addr_q    <= cmd_addr;
                        left_q    <= cmd_len;
                        be_q      <= cmd_be;
                        wdata_q   <= cmd_wdata;
                        state_q   <= ST_STRB;
                    end
                end
                ST_STRB: begin
                    ad_q    <= addr_q;
                    rw_q    <= (wr_q == RW_WRITE) ? RW_WRITE : RW_READ;
                    od_q    <= (wr_q == RW_WRITE) ? wdata_q : '0;
                    as_q    <= 1'b1;
                    uds_q   <= be_q[1];
                    lds_q   <= be_q[0];
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dtack) begin
                        // A read without dv still completes the word; rd_data keeps its old value.
                        if (wr_q == RW_READ) begin
                            rd_valid_q <= dv;
                            if (dv) begin
                                rd_data_q <= id;
                            end
                        end
                        as_q    <= 1'b0;
                        uds_q   <= 1'b0;
                        lds_q   <= 1'b0;
                        state_q <= ST_RECV;
                    end else if (tmo_zero) begin
                        as_q    <= 1'b0;
                        uds_q   <= 1'b0;
                        lds_q   <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (!dtack) begin
                        if (left_q != '0) begin
                            left_q  <= left_q - 1'b1;
                            addr_q  <= addr_q + 1'b1;
                            state_q <= ST_STRB;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ack  = cmd_ack_q;
    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign done     = done_q;
    assign err      = err_q;
    assign ad       = ad_q;
    assign as       = as_q;
    assign rw       = rw_q;
    assign uds      = uds_q;
    assign lds      = lds_q;
    assign od       = od_q;

endmodule

// File: tb/tb_vram_bus_initiator.sv
// Bench for vram_bus_initiator: registered-dtack memory responder plus a
// word-level transfer model predicting bus cycles, read data and timing.
`timescale 1ns/1ps
module tb_vram_bus_initiator;

    localparam int unsigned AW  = 23;
    localparam int unsigned DW  = 16;
    localparam int unsigned LW  = 8;
    localparam int unsigned TMO = 255;

    logic          cl = 1'b0;
    logic          reset_n;
    logic          cmd_req, cmd_ack, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [1:0]    cmd_be;
    logic [DW-1:0] cmd_wdata;
    logic          busy, rd_valid, done, err;
    logic [DW-1:0] rd_data, od, id;
    logic [AW-1:0] ad;
    logic          as, rw, uds, lds;
    logic          dtack, dv;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Responder knobs
    bit unmapped_en = 1'b0;
    bit nodv        = 1'b0;

    vram_bus_initiator #(.AW(AW), .DW(DW), .LW(LW), .TMO(TMO)) dut (
        .cl(cl), .reset_n(reset_n),
        .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .ad(ad), .as(as), .rw(rw), .uds(uds), .lds(lds), .od(od),
        .dtack(dtack), .dv(dv), .id(id)
    );

    initial forever #5 cl = ~cl;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    function automatic logic [11:0] ridx(input logic [AW-1:0] a);
        return 12'(a[11:0] + {1'b0, a[22:12]});
    endfunction

    function automatic logic [15:0] init_pat(input logic [11:0] i);
        return 16'({4'h0, i} * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    // Responder memory: written only by the responder process
    logic [15:0] rmem [0:4095];
    bit          rv   [0:4095];

    function automatic logic [15:0] resp_word(input logic [AW-1:0] a);
        logic [11:0] i;
        i = ridx(a);
        return rv[i] ? rmem[i] : init_pat(i);
    endfunction

    initial begin
        logic [11:0] ri;
        logic [15:0] cur;
        dtack = 1'b0;
        dv    = 1'b0;
        id    = '0;
        forever begin
            @(posedge cl);
            if (as && (uds || lds) && !(unmapped_en && ad == 23'h7FFFFF) && !dtack) begin
                ri  = ridx(ad);
                cur = rv[ri] ? rmem[ri] : init_pat(ri);
                if (rw) begin
                    rmem[ri] = merge(cur, od, {uds, lds});
                    rv[ri]   = 1'b1;
                    dv <= 1'b0;
                end else begin
                    id <= cur;
                    dv <= !nodv;
                end
                dtack <= 1'b1;
            end else if (!as) begin
                dtack <= 1'b0;
                dv    <= 1'b0;
            end
        end
    end

    // Reference memory model
    logic [15:0] mmem [0:4095];
    bit          mv   [0:4095];

    function automatic logic [15:0] model_read(input logic [AW-1:0] a);
        logic [11:0] i;
        i = ridx(a);
        return mv[i] ? mmem[i] : init_pat(i);
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [1:0] be, input logic [15:0] d);
        logic [11:0] i;
        i = ridx(a);
        mmem[i] = merge(model_read(a), d, be);
        mv[i]   = 1'b1;
    endtask

    // Bus monitor (negedge sampling)
    int unsigned   cyc = 0;
    logic [AW-1:0] adq [$];
    logic          rwq [$];
    logic [DW-1:0] odq [$];
    logic [1:0]    beq [$];
    logic [DW-1:0] rdq [$];
    int unsigned   done_n, err_n, ack_n, stab_bad;
    int unsigned   done_cyc, err_cyc, ack_cyc, first_as_cyc, last_as_cyc;
    bit            first_seen;

    task automatic clear_mon();
        adq.delete(); rwq.delete(); odq.delete(); beq.delete(); rdq.delete();
        done_n = 0; err_n = 0; ack_n = 0; stab_bad = 0; first_seen = 1'b0;
        done_cyc = 0; err_cyc = 0; ack_cyc = 0; first_as_cyc = 0; last_as_cyc = 0;
    endtask

    initial begin
        logic as_p;
        logic [AW+DW+2:0] snap;
        as_p = 1'b0;
        snap = '0;
        clear_mon();
        forever begin
            @(negedge cl);
            cyc++;
            if (as && !as_p) begin
                adq.push_back(ad); rwq.push_back(rw); odq.push_back(od); beq.push_back({uds, lds});
                last_as_cyc = cyc;
                if (!first_seen) begin first_as_cyc = cyc; first_seen = 1'b1; end
            end
            if (as && as_p && ({ad, rw, od, uds, lds} != snap)) stab_bad++;
            if (rd_valid) rdq.push_back(rd_data);
            if (done)     begin done_n++; done_cyc = cyc; end
            if (err)      begin err_n++;  err_cyc  = cyc; end
            if (cmd_ack)  begin ack_n++;  ack_cyc  = cyc; end
            as_p = as;
            snap = {ad, rw, od, uds, lds};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] last_rd = '0;

    task automatic wait_end(input string tag, input int unsigned lim);
        bit got;
        got = 1'b0;
        for (int unsigned k = 0; k < lim; k++) begin
            @(negedge cl);
            if (done || err) begin got = 1'b1; break; end
        end
        if (!got) chk({tag, ".end_bound"}, 32'd0, 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic [1:0] be, input logic [DW-1:0] wd);
        int unsigned   n_exp;
        bit            exp_err, got;
        logic [AW-1:0] a;
        logic [AW-1:0] exp_ad [$];
        logic [DW-1:0] exp_rd [$];
        n_exp = 0; exp_err = 1'b0;
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            a = addr + AW'(i);
            exp_ad.push_back(a);
            n_exp++;
            if (be == 2'b00 || (unmapped_en && a == 23'h7FFFFF)) begin exp_err = 1'b1; break; end
            if (wr) model_write(a, be, wd);
            else if (!nodv) exp_rd.push_back(model_read(a));
        end

        clear_mon();
        @(posedge cl); #1;
        cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_be = be; cmd_wdata = wd;
        cmd_req = 1'b1;
        got = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge cl);
            if (cmd_ack) begin got = 1'b1; break; end
        end
        cmd_req = 1'b0;
        if (!got) chk({tag, ".ack_bound"}, 32'd0, 32'd1);
        else chk({tag, ".busy_at_ack"}, 32'(busy), 32'd1);
        wait_end(tag, (32'(len) + 1) * 8 + TMO + 20);
        @(negedge cl); @(negedge cl);

        chk({tag, ".ncyc"}, adq.size(), n_exp);
        for (int unsigned i = 0; i < n_exp && i < adq.size(); i++) begin
            chk($sformatf("%s.ad%0d", tag, i), 32'(adq[i]), 32'(exp_ad[i]));
            chk($sformatf("%s.rw%0d", tag, i), 32'(rwq[i]), 32'(wr));
            chk($sformatf("%s.od%0d", tag, i), 32'(odq[i]), wr ? 32'(wd) : 32'd0);
            chk($sformatf("%s.be%0d", tag, i), 32'(beq[i]), 32'(be));
        end
        chk({tag, ".done_n"}, done_n, exp_err ? 32'd0 : 32'd1);
        chk({tag, ".err_n"}, err_n, exp_err ? 32'd1 : 32'd0);
        chk({tag, ".ack_n"}, ack_n, 32'd1);
        chk({tag, ".stable"}, stab_bad, 32'd0);
        chk({tag, ".idle_bus"}, {29'd0, busy, as, uds, lds}, 32'd0);
        chk({tag, ".ack2as"}, first_as_cyc - ack_cyc, 32'd1);
        if (exp_err) chk({tag, ".tmo_cycles"}, err_cyc - last_as_cyc, TMO);
        else         chk({tag, ".as2done"}, done_cyc - first_as_cyc, 5 * n_exp - 1);
        chk({tag, ".nrd"}, rdq.size(), exp_rd.size());
        for (int unsigned i = 0; i < exp_rd.size() && i < rdq.size(); i++)
            chk($sformatf("%s.rd%0d", tag, i), 32'(rdq[i]), 32'(exp_rd[i]));
        if (exp_rd.size() != 0) last_rd = exp_rd[exp_rd.size() - 1];
        chk({tag, ".rd_hold"}, 32'(rd_data), 32'(last_rd));
        if (wr)
            for (int unsigned i = 0; i < n_exp; i++)
                chk($sformatf("%s.mem%0d", tag, i), 32'(resp_word(exp_ad[i])), 32'(model_read(exp_ad[i])));
    endtask

    initial begin
        bit got;
        reset_n = 1'b0; cmd_req = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_be = '0; cmd_wdata = '0;
        repeat (3) @(negedge cl);
        chk("rst.outs", {cmd_ack, busy, rd_valid, done, err, as, rw, uds, lds}, 32'd0);
        chk("rst.ad_od_rd", 32'(ad) | 32'(od) | 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge cl);

        run_cmd("wr1",   1'b1, 23'h400000, 8'd0, 2'b11, 16'hA5C3);
        chk("wr1.vram", 32'(resp_word(23'h400000)), 32'hA5C3);
        run_cmd("rd1",   1'b0, 23'h400000, 8'd0, 2'b11, 16'h0000);
        run_cmd("fill",  1'b1, 23'h00E000, 8'd3, 2'b01, 16'h1234);
        run_cmd("fillrd",1'b0, 23'h00E000, 8'd3, 2'b11, 16'h0000);
        unmapped_en = 1'b1;
        run_cmd("unmap", 1'b0, 23'h7FFFFF, 8'd2, 2'b11, 16'h0000);
        unmapped_en = 1'b0;
        run_cmd("wrap",  1'b1, 23'h7FFFFF, 8'd1, 2'b10, 16'hBEEF);
        run_cmd("be00",  1'b1, 23'h000100, 8'd1, 2'b00, 16'h5555);
        nodv = 1'b1;
        run_cmd("nodv",  1'b0, 23'h00E001, 8'd1, 2'b11, 16'h0000);
        nodv = 1'b0;

        for (int unsigned r = 0; r < 12; r++) begin
            run_cmd($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                    23'h200000 | 23'($urandom_range(0, 255)), 8'($urandom_range(0, 4)),
                    2'($urandom_range(1, 3)), 16'($urandom));
        end

        // Asynchronous reset while waiting for dtack
        clear_mon();
        @(posedge cl); #1;
        cmd_wr = 1'b0; cmd_addr = 23'h000010; cmd_len = 8'd3; cmd_be = 2'b11; cmd_req = 1'b1;
        got = 1'b0;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge cl);
            if (cmd_ack) cmd_req = 1'b0;
            if (as) begin got = 1'b1; break; end
        end
        cmd_req = 1'b0;
        if (!got) chk("arst.as_bound", 32'd0, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("arst.strobes", {29'd0, as, uds, lds}, 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        clear_mon();
        repeat (2) @(negedge cl);
        reset_n = 1'b1;
        repeat (10) @(negedge cl);
        chk("arst.no_done_err", done_n + err_n, 32'd0);
        chk("arst.idle", {30'd0, busy, as}, 32'd0);
        chk("arst.ad_rd", 32'(ad) | 32'(rd_data), 32'd0);
        last_rd = '0;

        // cmd_req held through a transfer: only re-accepted the cycle after done
        model_write(23'h000020, 2'b11, 16'hC0DE);
        clear_mon();
        @(posedge cl); #1;
        cmd_wr = 1'b1; cmd_addr = 23'h000020; cmd_len = 8'd0; cmd_be = 2'b11;
        cmd_wdata = 16'hC0DE; cmd_req = 1'b1;
        wait_end("hold1", 40);
        @(negedge cl);
        cmd_req = 1'b0;
        chk("hold.ack_n", ack_n, 32'd2);
        chk("hold.ack_after_done", ack_cyc - done_cyc, 32'd1);
        wait_end("hold2", 40);
        @(negedge cl); @(negedge cl);
        chk("hold.done_n", done_n, 32'd2);
        chk("hold.ncyc", adq.size(), 32'd2);
        chk("hold.mem", 32'(resp_word(23'h000020)), 32'(model_read(23'h000020)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
